// File: rtl/row_stream_feeder.sv
// row_stream_feeder: holds an N x K operand tile in internal RAM and streams it,
// one column per accepted cycle, into the west edge of an N-row systolic array.
// Supports multi-pass replay of the tile and array backpressure.
// Optional build macro: ROW_STREAM_SKEW_EN adds i ready-gated stages on row i
// so that rows leave as a diagonal wavefront.
//
// Handshake: valid_o[i] qualifies data_o[i]; a beat on row i transfers in any
// cycle where valid_o[i]=1 and ready_i=1. While ready_i=0 the whole output pipe
// and the column/pass counters hold, so data_o/valid_o stay stable until taken.
module row_stream_feeder #(
  parameter int N          = 8,
  parameter int K          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int PASS_W     = 4,
  localparam int RW        = (N > 1) ? $clog2(N) : 1,
  localparam int CW        = (K > 1) ? $clog2(K) : 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  wr_en_i,
  input  logic [RW-1:0]         wr_row_i,
  input  logic [CW-1:0]         wr_col_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_drop_o,
  input  logic                  start_i,
  input  logic [PASS_W-1:0]     passes_i,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o [0:N-1],
  output logic [N-1:0]          valid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            state_o
);

`ifdef ROW_STREAM_SKEW_EN
  localparam int DEPTH = N;
  localparam bit SKEW  = 1'b1;
`else
  localparam int DEPTH = 1;
  localparam bit SKEW  = 1'b0;
`endif

  localparam logic [RW:0] ROW_LIM = (RW+1)'(N);
  localparam logic [CW:0] COL_LIM = (CW+1)'(K);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [PASS_W-1:0]     pass_q, pass_d;
  logic [PASS_W-1:0]     passes_q, passes_d;
  logic                  wr_drop_q, wr_drop_d;
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [DATA_WIDTH-1:0] pipe_q [0:DEPTH-1][0:N-1];
  logic [DATA_WIDTH-1:0] pipe_d [0:DEPTH-1][0:N-1];
  logic [DATA_WIDTH-1:0] ram_q  [0:N-1][0:K-1];
  logic                  wr_ok;
  logic                  issue;

  // Next-state logic: write acceptance, output pipe shift, FSM and counters.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    pass_d    = pass_q;
    passes_d  = passes_q;
    vld_d     = vld_q;
    pipe_d    = pipe_q;

    wr_ok     = wr_en_i && (state_q == ST_IDLE) &&
                ({1'b0, wr_row_i} < ROW_LIM) && ({1'b0, wr_col_i} < COL_LIM);
    wr_drop_d = wr_en_i && !wr_ok;
    issue     = (state_q == ST_STREAM) && ready_i;

    // Stage 0 loads the current column (or zeros when nothing is issued);
    // later stages only exist with skew and simply shift.
    if (ready_i) begin
      vld_d[0] = issue;
      for (int r = 0; r < N; r++) begin
        pipe_d[0][r] = issue ? ram_q[r][col_q] : '0;
      end
      for (int s = 1; s < DEPTH; s++) begin
        vld_d[s]  = vld_q[s-1];
        pipe_d[s] = pipe_q[s-1];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_STREAM;
          col_d    = '0;
          pass_d   = '0;
          passes_d = (passes_i == '0) ? PASS_W'(1) : passes_i;
        end
      end
      ST_STREAM: begin
        if (ready_i) begin
          if (col_q == CW'(K-1)) begin
            col_d  = '0;
            pass_d = pass_q + PASS_W'(1);
            if (pass_q == passes_q - PASS_W'(1)) state_d = ST_DRAIN;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (ready_i && (vld_d == '0)) state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and output pipe registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      pass_q    <= '0;
      passes_q  <= '0;
      wr_drop_q <= 1'b0;
      vld_q     <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        for (int r = 0; r < N; r++) begin
          pipe_q[s][r] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      pass_q    <= pass_d;
      passes_q  <= passes_d;
      wr_drop_q <= wr_drop_d;
      vld_q     <= vld_d;
      pipe_q    <= pipe_d;
    end
  end

  // Tile RAM: not reset, so a loaded tile survives a reset and can be replayed.
  always_ff @(posedge clk_i) begin
    if (wr_ok) ram_q[wr_row_i][wr_col_i] <= wr_data_i;
  end

  // Row r is taken from stage r with skew, otherwise from stage 0.
  for (genvar r = 0; r < N; r++) begin : g_row
    localparam int STG = SKEW ? r : 0;
    assign data_o[r]  = pipe_q[STG][r];
    assign valid_o[r] = vld_q[STG];
  end

  assign busy_o    = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign done_o    = (state_q == ST_DONE);
  assign wr_drop_o = wr_drop_q;
  assign state_o   = state_q;

endmodule
